stream_demux_1xn: RTL
=====================

// Module: stream_demux_1xn
// PURPOSE
//   Registered 1-to-N stream demultiplexer; parametrised successor of the 1x4 combinational demux.
//   Routes each accepted input word to output channel in_sel through a one-entry register per channel.
//   Uses a valid/ready handshake on every side, so each channel back-pressures independently.
//   Sits between a single producer and N consumers in the datapath.
// PARAMETERS
//   N      4   number of output channels, 2..16
//   W      8   data width in bits, >=1
//   CNT_W  16  per-channel transfer counter width (used only with DEMUX_CNT_EN)
//   SEL_W  derived: $clog2(N); not overridable
// PORTS
//   clk        in   1        system clock, rising edge; the only clock
//   rst        in   1        reset, asynchronous and active-high
//   in_valid   in   1        input word valid
//   in_ready   out  1        input word accepted this cycle when in_valid & in_ready
//   in_sel     in   SEL_W    destination channel index
//   in_data    in   W        input word
//   out_valid  out  N        bit k: channel k register holds a word
//   out_ready  in   N        bit k: consumer k takes the word this cycle
//   out_data   out  N*W      channel k data in slice [k*W +: W]
//   err_sel    out  1        one-cycle pulse: an accepted word had in_sel >= N
//   out_cnt    out  N*CNT_W  DEMUX_CNT_EN only: channel k count in slice [k*CNT_W +: CNT_W]
// BEHAVIOUR
//   - Reset (async assert, released on a clk edge): out_valid=0, out_data=0, err_sel=0, out_cnt=0.
//     Any word held at reset is discarded.
//   - in_ready (combinational):
//     - in_sel <  N: in_ready = !out_valid[in_sel] | out_ready[in_sel]
//     - in_sel >= N: in_ready = 1
//     - rst high:    in_ready = 0
//   - Accept (in_valid & in_ready) with in_sel=k<N: at the next edge out_data[k]<=in_data and out_valid[k]<=1.
//     Latency is 1 clock from accept to out_valid.
//   - Channel k drain (out_valid[k] & out_ready[k]) with no load to k: at the next edge out_valid[k]<=0.
//     out_data[k] holds its last value.
//   - Drain and load of k in the same cycle: the new word is loaded and out_valid[k] stays 1.
//     Full throughput is 1 word/clk per channel.
//   - Each channel register is a 2-state FSM, EMPTY <-> FULL:
//     - EMPTY->FULL on load
//     - FULL->EMPTY on drain without load
//     - FULL->FULL on drain with load, or on hold
//   - Channels other than in_sel are unaffected by an accept. Drains on different channels are independent and simultaneous.
//   - While FULL and not drained, out_data[k] and out_valid[k] stay stable. The producer must hold in_valid/in_sel/in_data until accepted.
//   - Out-of-range in_sel (possible only when N is not a power of 2): the word is accepted and dropped, and err_sel=1 on the next clock for 1 cycle.
//   - in_valid=0: no state change except drains.
// CONFIGURATION
//   DEMUX_CNT_EN defined:
//     - out_cnt[k] increments on every channel-k drain handshake.
//     - Wraps modulo 2^CNT_W.
//     - Cleared by reset.
//   DEMUX_CNT_EN undefined:
//     - out_cnt port and counters are absent.
//     - All other behaviour is identical.
// STRUCTURE
//   - Package demux_pkg: function sel_w(N) = $clog2(N); typedef chan_state_e {EMPTY, FULL}.
//   - Sub-module demux_chan_reg (W): one-entry valid/ready register with load/drain logic.
//     Instantiated N times via generate; the top holds sel decode, in_ready mux, err_sel and counters.
// TESTING
//   1. Reset: rst=1 mid-traffic with out_valid=4'b0101
//      -> out_valid=0, err_sel=0, in_ready=0 immediately, async to clk.
//   2. Sweep N=4, W=8, out_ready=all 1: sel=0..3 with data A0..A3 on consecutive clocks
//      -> out_valid[k]=1 with A_k exactly 1 clk after its accept; others stay 0.
//   3. Back-pressure: out_ready[2]=0, send 0x11 then 0x22 to ch2
//      -> first accepted; in_ready=0 for the second until out_ready[2]=1.
//      Then 0x11 drains and 0x22 loads on the same edge; out_valid[2] stays 1.
//   4. Independence: ch1 stalled FULL, send 0x33 to ch3
//      -> accepted immediately; ch1 data and valid unchanged.
//   5. N=5 (SEL_W=3): in_sel=6, in_valid=1
//      -> in_ready=1, err_sel pulses 1 clk, out_valid unchanged.
//   6. DEMUX_CNT_EN, CNT_W=2: 5 drains on ch0 -> out_cnt[0]=1 (wrap). Undefined build: port absent, tests 1-5 pass.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-N stream demultiplexer.
// Optional per-channel drain counters are enabled with the DEMUX_CNT_EN macro.
package demux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } chan_state_e;

  // Select width for n channels; never below one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry valid/ready channel register: loads a word, holds it until drained.
// A drain and a load in the same cycle keep the register full (1 word/clk).
module demux_chan_reg
  import demux_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  chan_state_e state;
  chan_state_e state_nxt;
  logic        drain;

  assign drain = (state == FULL) & ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (drain && !load) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    valid = (state == FULL);
  end

  // Data holds its last value after a drain; only a load overwrites it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N valid/ready stream demultiplexer with per-channel back-pressure.
// Define DEMUX_CNT_EN to add per-channel drain counters on out_cnt.
module stream_demux_1xn
  import demux_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8,
`ifdef DEMUX_CNT_EN
  parameter int unsigned CNT_W = 16,
`endif
  localparam int unsigned SEL_W = sel_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [W-1:0]     in_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [N*W-1:0]   out_data,
  output logic             err_sel
`ifdef DEMUX_CNT_EN
  ,
  output logic [N*CNT_W-1:0] out_cnt
`endif
);

  logic         sel_hit;
  logic         sel_valid;
  logic         sel_ready;
  logic         accept;
  logic [N-1:0] load;

  // Decode in_sel against real channels; an out-of-range select never stalls.
  always_comb begin
    sel_hit   = 1'b0;
    sel_valid = 1'b0;
    sel_ready = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_hit   = 1'b1;
        sel_valid = out_valid[k];
        sel_ready = out_ready[k];
      end
    end
    in_ready = !rst && (!sel_hit || !sel_valid || sel_ready);
    accept   = in_valid && in_ready;
    load     = '0;
    for (int k = 0; k < int'(N); k++) begin
      load[k] = accept && (in_sel == SEL_W'(k));
    end
  end

  for (genvar k = 0; k < int'(N); k++) begin : g_chan
    demux_chan_reg #(
      .W (W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*W +: W])
    );
  end

  // Accepted-and-dropped word flags a one-cycle error pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sel <= 1'b0;
    end else begin
      err_sel <= accept && !sel_hit;
    end
  end

`ifdef DEMUX_CNT_EN
  for (genvar k = 0; k < int'(N); k++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (out_valid[k] && out_ready[k]) begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign out_cnt[k*CNT_W +: CNT_W] = cnt;
  end
`endif

endmodule
